// File: rtl/arb_prio16_pkg.sv
// arb_prio16_pkg
//   Shared definitions for the 16-way priority / round-robin arbiter:
//   FSM state encoding, requester count and grant-id width.
package arb_prio16_pkg;

    localparam int NUM_REQ = 16;
    localparam int ID_W    = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/arb_prio16_enc.sv
// prio_enc16
//   Combinational circular priority encoder. Scans vec downward starting at
//   index start, wrapping 0 -> 15, and visits every index once, so the last
//   index examined is start+1.
//   Fixed priority:  start = 15        -> scan 15..0.
//   Round robin:     start = last_id-1 -> scan ends at last_id.
// Ports
//   vec   in  16  candidate vector
//   start in  4   first index examined
//   id    out 4   index of the first set bit found (0 when none)
//   vld   out 1   at least one bit of vec is set
import arb_prio16_pkg::*;

module prio_enc16 (
    input  logic [NUM_REQ-1:0] vec,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    id,
    output logic               vld
);

    logic [ID_W-1:0] idx;

    // Walk from the far end of the scan back toward start; the last hit
    // written is the one closest to start, i.e. the highest priority.
    always_comb begin
        id  = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = start - ID_W'(i);
            if (vec[idx]) begin
                id  = idx;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_prio16.sv
// arb_prio16
//   16-requester arbiter with fixed-priority (index 15 highest) or
//   round-robin selection and a maximum grant hold time.
//   Handshake: a grant is issued from IDLE only; the owner keeps it while
//   req[gnt_id] stays high and releases it by pulsing done (done is only
//   meaningful while gnt_vld=1). Dropping en or reaching MAX_HOLD cycles
//   also revokes it. Every release is followed by one IDLE cycle with
//   gnt_vld=0; there is no preemption.
// Ports
//   clk       in  1   rising-edge clock
//   rst       in  1   synchronous active-high reset
//   en        in  1   arbiter enable (low blocks and revokes grants)
//   rr_mode   in  1   0 = fixed priority, 1 = round robin
//   req       in  16  request vector
//   done      in  1   owner release pulse
//   gnt       out 16  one-hot grant (registered)
//   gnt_id    out 4   granted index (registered)
//   gnt_vld   out 1   grant held
//   timeout   out 1   one-cycle pulse when revoked by the hold limit alone
//   fsm_state out 1   current FSM state, for observation
import arb_prio16_pkg::*;

module arb_prio16 #(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               rr_mode,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_vld,
    output logic               timeout,
    output state_t             fsm_state
);

    state_t          state;
    logic [7:0]      hold_cnt;
    logic [ID_W-1:0] last_id;

    logic [ID_W-1:0] start;
    logic [ID_W-1:0] win_id;
    logic            win_vld;
    logic            owner_req;
    logic            hold_hit;
    logic            release_now;

    // last_id-1 wraps 0 -> 15, so after reset round robin matches fixed.
    assign start = rr_mode ? (last_id - 4'd1) : 4'd15;

    prio_enc16 u_enc (
        .vec   (req),
        .start (start),
        .id    (win_id),
        .vld   (win_vld)
    );

    assign owner_req   = req[gnt_id];
    assign hold_hit    = (hold_cnt == 8'(MAX_HOLD));
    assign release_now = done | ~owner_req | ~en | hold_hit;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (en && win_vld) begin
                        gnt      <= NUM_REQ'(1) << win_id;
                        gnt_id   <= win_id;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= 8'd1;
                        last_id  <= win_id;
                        state    <= BUSY;
                    end else begin
                        gnt      <= '0;
                        gnt_id   <= '0;
                        gnt_vld  <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        gnt      <= '0;
                        gnt_id   <= '0;
                        gnt_vld  <= 1'b0;
                        hold_cnt <= '0;
                        state    <= IDLE;
                        // Any other release cause suppresses the timeout.
                        timeout  <= hold_hit & ~done & owner_req & en;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                        timeout  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_prio16.sv
// tb_arb_prio16
//   Directed bench for arb_prio16. The main instance uses MAX_HOLD=4; a
//   second instance with MAX_HOLD=1 shares the inputs and is checked only
//   in the hold-limit scenario.
import arb_prio16_pkg::*;

module tb_arb_prio16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rr_mode;
    logic [15:0] req;
    logic        done;

    logic [15:0] gnt,  gnt1;
    logic [3:0]  gnt_id, gnt_id1;
    logic        gnt_vld, gnt_vld1;
    logic        timeout, timeout1;
    state_t      fsm_state, fsm_state1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    arb_prio16 #(.MAX_HOLD(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .req(req),
        .done(done), .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld),
        .timeout(timeout), .fsm_state(fsm_state)
    );

    arb_prio16 #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .req(req),
        .done(done), .gnt(gnt1), .gnt_id(gnt_id1), .gnt_vld(gnt_vld1),
        .timeout(timeout1), .fsm_state(fsm_state1)
    );

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [15:0] e_gnt,
                               input logic [3:0] e_id, input logic e_vld,
                               input logic e_to);
        check({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
        check({tag, ".gnt_id"},  32'(gnt_id),  32'(e_id));
        check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(e_vld));
        check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        en = 1'b1; rr_mode = 1'b0; req = '0; done = 1'b0;

        // Reset state
        do_reset();
        check_grant("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        check("reset.state", 32'(fsm_state), 32'(IDLE));
        tick();
        check_grant("idle_noreq", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Fixed priority: 0x0090 -> id 7, then done release
        req = 16'h0090;
        tick();
        check_grant("fixed_0090", 16'h0080, 4'd7, 1'b1, 1'b0);
        check("fixed_0090.state", 32'(fsm_state), 32'(BUSY));
        done = 1'b1;
        tick();
        check_grant("fixed_done", 16'h0000, 4'd0, 1'b0, 1'b0);
        done = 1'b0; req = '0;
        tick();

        // Round robin 0x8001 from reset: 15, 0, 15, 0 with idle gaps
        do_reset();
        rr_mode = 1'b1; req = 16'h8001;
        tick();
        check_grant("rr_g0", 16'h8000, 4'd15, 1'b1, 1'b0);
        done = 1'b1; tick(); done = 1'b0;
        check_grant("rr_gap0", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        check_grant("rr_g1", 16'h0001, 4'd0, 1'b1, 1'b0);
        done = 1'b1; tick(); done = 1'b0;
        check_grant("rr_gap1", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        check_grant("rr_g2", 16'h8000, 4'd15, 1'b1, 1'b0);
        done = 1'b1; tick(); done = 1'b0;
        check_grant("rr_gap2", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        check_grant("rr_g3", 16'h0001, 4'd0, 1'b1, 1'b0);
        done = 1'b1; req = '0; tick(); done = 1'b0;

        // Hold limit: MAX_HOLD=4 main instance, MAX_HOLD=1 second instance
        do_reset();
        rr_mode = 1'b0; req = 16'h0008;
        tick();
        check_grant("hold_c1", 16'h0008, 4'd3, 1'b1, 1'b0);
        check("mh1_c1.gnt_vld", 32'(gnt_vld1), 32'd1);
        check("mh1_c1.gnt_id",  32'(gnt_id1),  32'd3);
        tick();
        check_grant("hold_c2", 16'h0008, 4'd3, 1'b1, 1'b0);
        check("mh1_c2.gnt_vld", 32'(gnt_vld1), 32'd0);
        check("mh1_c2.timeout", 32'(timeout1), 32'd1);
        tick();
        check_grant("hold_c3", 16'h0008, 4'd3, 1'b1, 1'b0);
        check("mh1_c3.gnt_vld", 32'(gnt_vld1), 32'd1);
        check("mh1_c3.timeout", 32'(timeout1), 32'd0);
        tick();
        check_grant("hold_c4", 16'h0008, 4'd3, 1'b1, 1'b0);
        tick();
        check_grant("hold_to", 16'h0000, 4'd0, 1'b0, 1'b1);
        tick();
        check_grant("hold_regrant", 16'h0008, 4'd3, 1'b1, 1'b0);
        // done on the limit cycle suppresses timeout
        tick(); tick(); tick();
        check_grant("hold_c4b", 16'h0008, 4'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        check_grant("hold_done_wins", 16'h0000, 4'd0, 1'b0, 1'b0);
        done = 1'b0; req = '0;
        tick();

        // Owner drops its request
        req = 16'h0020;
        tick();
        check_grant("drop_g", 16'h0020, 4'd5, 1'b1, 1'b0);
        tick();
        req = '0;
        tick();
        check_grant("drop_rel", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Reset mid-grant, round robin restarts from 15
        rr_mode = 1'b1; req = 16'h0200;
        tick();
        check_grant("rst_g9", 16'h0200, 4'd9, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_grant("rst_mid", 16'h0000, 4'd0, 1'b0, 1'b0);
        check("rst_mid.state", 32'(fsm_state), 32'(IDLE));
        req = 16'h8201;
        tick();
        check_grant("rst_rr15", 16'h8000, 4'd15, 1'b1, 1'b0);
        done = 1'b1; tick(); done = 1'b0;

        // en=0 revokes and blocks; rr_mode change while BUSY is ignored
        rr_mode = 1'b0; req = 16'hFFFF;
        tick();
        check_grant("en_g15", 16'h8000, 4'd15, 1'b1, 1'b0);
        rr_mode = 1'b1;
        tick();
        check_grant("en_rrchg", 16'h8000, 4'd15, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        check_grant("en_rel", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        check_grant("en_block", 16'h0000, 4'd0, 1'b0, 1'b0);
        rr_mode = 1'b0; en = 1'b1;
        tick();
        check_grant("en_back", 16'h8000, 4'd15, 1'b1, 1'b0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
